grf_write_arbiter: RTL and testbench

Write-port arbiter and scoreboard for the pipeline's `grf` register file. It shares the single write port between two requesters: the W-stage writeback, which has fixed priority and never stalls, and a secondary multi-cycle result source using a valid/ready handshake and buffered in a small FIFO. It also tracks destination registers with outstanding secondary results so decode can stall on them. It sits between W stage / secondary unit and `grf`, and drives `grf.regwrite/wa/wd` directly.

---
 rtl/grf_arb_pkg.sv | 25 ++
 rtl/grf_write_arbiter_if.sv | 21 ++
 rtl/grf_arb_fifo.sv | 53 +++++
 rtl/grf_write_arbiter.sv | 161 ++++++++++++++++
 tb/tb_grf_write_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/grf_arb_pkg.sv
// grf_arb_pkg: shared types and defaults for the grf write-port arbiter.
//   REG_AW / DATA_W   : register-address and data widths of grf
//   DEPTH_DEF         : default secondary FIFO depth
//   STARVE_MAX_DEF    : default starvation threshold
//   grf_arb_entry_t   : secondary FIFO entry {wa, wd[, pc]}
// Optional feature macro: GRF_ARB_TRACE_EN (adds the pc field to entries).
package grf_arb_pkg;

  localparam int unsigned REG_AW         = 5;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned DEPTH_DEF      = 2;
  localparam int unsigned STARVE_MAX_DEF = 8;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    reg_addr_t wa;
    data_t     wd;
`ifdef GRF_ARB_TRACE_EN
    data_t     pc;
`endif
  } grf_arb_entry_t;

endpackage

// File: rtl/grf_write_arbiter_if.sv
// grf_write_arbiter_if: valid/ready result channel from the secondary
// multi-cycle unit into the grf write arbiter.
//   s_valid : result valid            (master -> slave)
//   s_ready : arbiter FIFO can accept (slave  -> master)
//   s_wa    : destination register    (master -> slave)
//   s_wd    : result data             (master -> slave)
//   s_pc    : instruction PC, trace only (master -> slave)
interface grf_write_arbiter_if;
  import grf_arb_pkg::*;

  logic      s_valid;
  logic      s_ready;
  reg_addr_t s_wa;
  data_t     s_wd;
  data_t     s_pc;

  modport master (output s_valid, output s_wa, output s_wd, output s_pc,
                  input  s_ready);
  modport slave  (input  s_valid, input  s_wa, input  s_wd, input  s_pc,
                  output s_ready);
endinterface

// File: rtl/grf_arb_fifo.sv
// grf_arb_fifo: DEPTH-entry circular FIFO holding secondary results.
//   clk   : clock
//   rst   : asynchronous active-low reset (empties the FIFO)
//   push  : write din at the tail (caller guarantees not full)
//   pop   : drop the head entry (caller guarantees not empty)
//   din   : entry to write
//   head  : current head entry (valid when count != 0)
//   count : number of stored entries, 0..DEPTH
module grf_arb_fifo
  import grf_arb_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  grf_arb_entry_t         din,
  output grf_arb_entry_t         head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);

  grf_arb_entry_t mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/grf_write_arbiter.sv
// grf_write_arbiter: shares the single grf write port between the W-stage
// writeback (fixed priority, never stalls) and a FIFO-buffered secondary
// result source, and keeps a busy scoreboard of registers awaiting a
// secondary result so decode can stall on them.
//   clk, rst           : clock, asynchronous active-low reset
//   w_we/w_wa/w_wd     : W-stage write request
//   w_pc               : W-stage PC (trace only)
//   sec                : secondary result channel (slave modport)
//   iss_valid/iss_wa   : secondary op issue and its destination
//   rs_a/rt_a          : decode source queries
//   busy_rs/busy_rt    : queried register has a pending secondary write
//   stall_req          : asks the pipeline to bubble W so the FIFO drains
//   err                : sticky protocol-error flag
//   regwrite/wa/wd     : grf write port
// Optional feature macro: GRF_ARB_TRACE_EN (prints every granted write).
module grf_write_arbiter
  import grf_arb_pkg::*;
#(
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      w_we,
  input  reg_addr_t                 w_wa,
  input  data_t                     w_wd,
  input  data_t                     w_pc,
  grf_write_arbiter_if.slave        sec,
  input  logic                      iss_valid,
  input  reg_addr_t                 iss_wa,
  input  reg_addr_t                 rs_a,
  input  reg_addr_t                 rt_a,
  output logic                      busy_rs,
  output logic                      busy_rt,
  output logic                      stall_req,
  output logic                      err,
  output logic                      regwrite,
  output reg_addr_t                 wa,
  output data_t                     wd
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]             count;
  grf_arb_entry_t            head;
  grf_arb_entry_t            push_entry;
  logic                      push;
  logic                      pop;
  logic                      fifo_nonempty;

  logic [(1<<REG_AW)-1:0]    sb;
  logic [(1<<REG_AW)-1:0]    sb_d;
  logic                      err_d;
  logic [7:0]                starve_cnt;
  logic [7:0]                starve_cnt_d;
  logic                      stall_d;

  assign fifo_nonempty = (count != '0);
  assign sec.s_ready   = (count != CW'(DEPTH));
  assign push          = sec.s_valid && sec.s_ready;
  assign pop           = !w_we && fifo_nonempty;

  always_comb begin
    push_entry    = '0;
    push_entry.wa = sec.s_wa;
    push_entry.wd = sec.s_wd;
`ifdef GRF_ARB_TRACE_EN
    push_entry.pc = sec.s_pc;
`endif
  end

  grf_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .head  (head),
    .count (count)
  );

  // Port mux. The FIFO count is already zero while rst is low, but W could
  // still be requesting, so the enable is gated explicitly.
  always_comb begin
    regwrite = 1'b0;
    wa       = '0;
    wd       = '0;
    if (w_we) begin
      regwrite = 1'b1;
      wa       = w_wa;
      wd       = w_wd;
    end else if (fifo_nonempty) begin
      regwrite = 1'b1;
      wa       = head.wa;
      wd       = head.wd;
    end
    if (!rst) regwrite = 1'b0;
  end

  // Scoreboard: clear on grant first so a same-cycle issue to the same
  // register wins. Error checks look at the registered bits.
  always_comb begin
    sb_d  = sb;
    err_d = err;
    if (pop) sb_d[head.wa] = 1'b0;
    if (iss_valid && (iss_wa != '0)) begin
      if (sb[iss_wa]) err_d = 1'b1;
      sb_d[iss_wa] = 1'b1;
    end
    if (push && (sec.s_wa != '0) && !sb[sec.s_wa]) err_d = 1'b1;
    sb_d[0] = 1'b0;
  end

  // Starvation: the counter saturates; stall_req latches when the next count
  // hits the threshold and is only dropped by a FIFO grant.
  always_comb begin
    starve_cnt_d = starve_cnt;
    stall_d      = stall_req;
    if (!fifo_nonempty || pop) begin
      starve_cnt_d = '0;
    end else if (starve_cnt != '1) begin
      starve_cnt_d = starve_cnt + 1'b1;
    end
    if (pop) begin
      stall_d = 1'b0;
    end else if (starve_cnt_d == 8'(STARVE_MAX)) begin
      stall_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb         <= '0;
      err        <= 1'b0;
      starve_cnt <= '0;
      stall_req  <= 1'b0;
    end else begin
      sb         <= sb_d;
      err        <= err_d;
      starve_cnt <= starve_cnt_d;
      stall_req  <= stall_d;
    end
  end

  assign busy_rs = sb[rs_a];
  assign busy_rt = sb[rt_a];

`ifdef GRF_ARB_TRACE_EN
  data_t trace_pc;
  assign trace_pc = w_we ? w_pc : head.pc;

  always_ff @(posedge clk) begin
    if (rst && regwrite && (wa != '0))
      $display("%d@%h: $%d <= %h", $time, trace_pc, wa, wd);
  end
`else
  logic unused_pc;
  assign unused_pc = ^{w_pc, sec.s_pc};
`endif

endmodule

// File: tb/tb_grf_write_arbiter.sv
// tb_grf_write_arbiter: self-checking bench for grf_write_arbiter.
// Directed vector table, hand-written multi-cycle sequences (starvation,
// protocol error, asynchronous reset), then randomized traffic checked
// against a queue-based reference model.
module tb_grf_write_arbiter;
  import grf_arb_pkg::*;

  localparam int unsigned DEPTH      = 2;
  localparam int unsigned STARVE_MAX = 8;

  logic      clk = 1'b0;
  logic      rst = 1'b0;
  logic      w_we;
  reg_addr_t w_wa;
  data_t     w_wd;
  data_t     w_pc;
  logic      iss_valid;
  reg_addr_t iss_wa;
  reg_addr_t rs_a;
  reg_addr_t rt_a;
  logic      busy_rs, busy_rt, stall_req, err, regwrite;
  reg_addr_t wa;
  data_t     wd;

  int checks   = 0;
  int failures = 0;

  grf_write_arbiter_if sec_if();

  always #5 clk = ~clk;

  grf_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .w_we      (w_we),
    .w_wa      (w_wa),
    .w_wd      (w_wd),
    .w_pc      (w_pc),
    .sec       (sec_if),
    .iss_valid (iss_valid),
    .iss_wa    (iss_wa),
    .rs_a      (rs_a),
    .rt_a      (rt_a),
    .busy_rs   (busy_rs),
    .busy_rt   (busy_rt),
    .stall_req (stall_req),
    .err       (err),
    .regwrite  (regwrite),
    .wa        (wa),
    .wd        (wd)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    w_we = 1'b0; w_wa = '0; w_wd = '0; w_pc = '0;
    sec_if.s_valid = 1'b0; sec_if.s_wa = '0; sec_if.s_wd = '0; sec_if.s_pc = '0;
    iss_valid = 1'b0; iss_wa = '0; rs_a = '0; rt_a = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        w_we;
    logic [4:0]  w_wa;
    logic [31:0] w_wd;
    logic        s_valid;
    logic [4:0]  s_wa;
    logic [31:0] s_wd;
    logic        iss_valid;
    logic [4:0]  iss_wa;
    logic [4:0]  rs_a;
    logic [4:0]  rt_a;
    logic        e_rw;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_rdy;
    logic        e_brs;
    logic        e_brt;
    logic        e_stall;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(
    int unsigned we, int unsigned wwa, int unsigned wwd,
    int unsigned sv, int unsigned swa, int unsigned swd,
    int unsigned iv, int unsigned iwa, int unsigned rs, int unsigned rt,
    int unsigned rw, int unsigned ewa, int unsigned ewd,
    int unsigned rdy, int unsigned brs, int unsigned brt,
    int unsigned stl, int unsigned er);
    vec_t v;
    v.w_we = 1'(we); v.w_wa = 5'(wwa); v.w_wd = wwd;
    v.s_valid = 1'(sv); v.s_wa = 5'(swa); v.s_wd = swd;
    v.iss_valid = 1'(iv); v.iss_wa = 5'(iwa); v.rs_a = 5'(rs); v.rt_a = 5'(rt);
    v.e_rw = 1'(rw); v.e_wa = 5'(ewa); v.e_wd = ewd;
    v.e_rdy = 1'(rdy); v.e_brs = 1'(brs); v.e_brt = 1'(brt);
    v.e_stall = 1'(stl); v.e_err = 1'(er);
    return v;
  endfunction

  localparam int NVEC = 17;
  vec_t tbl [NVEC];

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
  } mentry_t;

  mentry_t    mq[$];
  bit         m_busy [32];
  int         m_starve;
  bit         m_stall;
  bit         m_err;
  logic [4:0] pend[$];

  task automatic model_reset();
    mq.delete();
    pend.delete();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_starve = 0;
    m_stall  = 1'b0;
    m_err    = 1'b0;
  endtask

  // One clock edge with the inputs currently applied.
  task automatic model_step();
    bit      grant_s;
    bit      acc;
    bit      had_entry;
    mentry_t g;
    grant_s   = !w_we && (mq.size() > 0);
    acc       = sec_if.s_valid && (mq.size() < DEPTH);
    had_entry = (mq.size() > 0);
    if (iss_valid && iss_wa != 0 && m_busy[iss_wa]) m_err = 1'b1;
    if (acc && sec_if.s_wa != 0 && !m_busy[sec_if.s_wa]) m_err = 1'b1;
    if (grant_s) begin
      g = mq.pop_front();
      if (g.wa != 0) m_busy[g.wa] = 1'b0;
    end
    if (iss_valid && iss_wa != 0) m_busy[iss_wa] = 1'b1;
    if (acc) mq.push_back('{wa: sec_if.s_wa, wd: sec_if.s_wd});
    if (grant_s || !had_entry) m_starve = 0;
    else m_starve++;
    if (grant_s) m_stall = 1'b0;
    else if (m_starve >= STARVE_MAX) m_stall = 1'b1;
  endtask

  task automatic model_check();
    bit         e_rw;
    logic [4:0] e_wa;
    logic [31:0] e_wd;
    e_rw = w_we || (mq.size() > 0);
    e_wa = w_we ? w_wa : (mq.size() > 0 ? mq[0].wa : 5'd0);
    e_wd = w_we ? w_wd : (mq.size() > 0 ? mq[0].wd : 32'd0);
    chk1("rnd_regwrite", regwrite, e_rw);
    if (e_rw) begin
      chk32("rnd_wa", 32'(wa), 32'(e_wa));
      chk32("rnd_wd", wd, e_wd);
    end
    chk1("rnd_s_ready", sec_if.s_ready, mq.size() < DEPTH);
    chk1("rnd_busy_rs", busy_rs, m_busy[rs_a]);
    chk1("rnd_busy_rt", busy_rt, m_busy[rt_a]);
    chk1("rnd_stall", stall_req, m_stall);
    chk1("rnd_err", err, m_err);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //                we wwa wwd          sv swa swd           iv iwa rs rt  rw ewa ewd          rdy brs brt stl err
    tbl[0]  = mk(0, 0, 0,            0, 0, 0,             0, 0, 5, 0,   0, 0, 0,             1, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0,            0, 0, 0,             1, 5, 5, 0,   0, 0, 0,             1, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0,            1, 5, 32'hDEADBEEF,  0, 0, 5, 0,   0, 0, 0,             1, 1, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0,            0, 0, 0,             0, 0, 5, 0,   1, 5, 32'hDEADBEEF,  1, 1, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0,            0, 0, 0,             0, 0, 5, 0,   0, 0, 0,             1, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0,            0, 0, 0,             1, 7, 0, 7,   0, 0, 0,             1, 0, 0, 0, 0);
    tbl[6]  = mk(1, 3, 32'h33,       1, 7, 32'h77,        0, 0, 0, 7,   1, 3, 32'h33,        1, 0, 1, 0, 0);
    tbl[7]  = mk(1, 3, 32'h333,      0, 0, 0,             0, 0, 0, 7,   1, 3, 32'h333,       1, 0, 1, 0, 0);
    tbl[8]  = mk(0, 0, 0,            0, 0, 0,             0, 0, 0, 7,   1, 7, 32'h77,        1, 0, 1, 0, 0);
    tbl[9]  = mk(0, 0, 0,            0, 0, 0,             0, 0, 0, 7,   0, 0, 0,             1, 0, 0, 0, 0);
    tbl[10] = mk(1, 1, 1,            0, 0, 0,             1, 10, 10, 0, 1, 1, 1,             1, 0, 0, 0, 0);
    tbl[11] = mk(1, 1, 1,            1, 10, 32'hA0,       1, 11, 10, 11, 1, 1, 1,            1, 1, 0, 0, 0);
    tbl[12] = mk(1, 1, 1,            1, 11, 32'hB0,       0, 0, 10, 11, 1, 1, 1,             1, 1, 1, 0, 0);
    tbl[13] = mk(1, 1, 1,            1, 12, 32'hC0,       0, 0, 10, 11, 1, 1, 1,             0, 1, 1, 0, 0);
    tbl[14] = mk(0, 0, 0,            0, 0, 0,             0, 0, 10, 11, 1, 10, 32'hA0,       0, 1, 1, 0, 0);
    tbl[15] = mk(0, 0, 0,            0, 0, 0,             0, 0, 10, 11, 1, 11, 32'hB0,       1, 0, 1, 0, 0);
    tbl[16] = mk(0, 0, 0,            0, 0, 0,             0, 0, 10, 11, 0, 0, 0,             1, 0, 0, 0, 0);

    // Reset state, with W requesting to show the enable is gated.
    idle();
    w_we = 1'b1; w_wa = 5'd4;
    #2;
    chk1("rst_regwrite", regwrite, 1'b0);
    chk1("rst_s_ready", sec_if.s_ready, 1'b1);
    chk1("rst_busy_rs", busy_rs, 1'b0);
    chk1("rst_stall", stall_req, 1'b0);
    chk1("rst_err", err, 1'b0);
    #10;
    rst = 1'b1;
    idle();
    tick();

    for (int i = 0; i < NVEC; i++) begin
      w_we = tbl[i].w_we; w_wa = tbl[i].w_wa; w_wd = tbl[i].w_wd;
      sec_if.s_valid = tbl[i].s_valid; sec_if.s_wa = tbl[i].s_wa; sec_if.s_wd = tbl[i].s_wd;
      iss_valid = tbl[i].iss_valid; iss_wa = tbl[i].iss_wa;
      rs_a = tbl[i].rs_a; rt_a = tbl[i].rt_a;
      #2;
      chk1($sformatf("vec%0d_regwrite", i), regwrite, tbl[i].e_rw);
      if (tbl[i].e_rw) begin
        chk32($sformatf("vec%0d_wa", i), 32'(wa), 32'(tbl[i].e_wa));
        chk32($sformatf("vec%0d_wd", i), wd, tbl[i].e_wd);
      end
      chk1($sformatf("vec%0d_s_ready", i), sec_if.s_ready, tbl[i].e_rdy);
      chk1($sformatf("vec%0d_busy_rs", i), busy_rs, tbl[i].e_brs);
      chk1($sformatf("vec%0d_busy_rt", i), busy_rt, tbl[i].e_brt);
      chk1($sformatf("vec%0d_stall", i), stall_req, tbl[i].e_stall);
      chk1($sformatf("vec%0d_err", i), err, tbl[i].e_err);
      tick();
    end

    // Starvation: entry waits behind W for STARVE_MAX cycles.
    idle();
    iss_valid = 1'b1; iss_wa = 5'd20;
    tick();
    idle();
    w_we = 1'b1; w_wa = 5'd2; w_wd = 32'h2;
    sec_if.s_valid = 1'b1; sec_if.s_wa = 5'd20; sec_if.s_wd = 32'h20202020;
    tick();
    sec_if.s_valid = 1'b0;
    rs_a = 5'd20;
    for (int k = 1; k <= STARVE_MAX; k++) begin
      #2;
      chk1($sformatf("starve_pre%0d", k), stall_req, 1'b0);
      tick();
    end
    w_we = 1'b0;
    #2;
    chk1("starve_stall", stall_req, 1'b1);
    chk1("starve_grant_rw", regwrite, 1'b1);
    chk32("starve_grant_wa", 32'(wa), 32'd20);
    chk32("starve_grant_wd", wd, 32'h20202020);
    tick();
    #2;
    chk1("starve_release", stall_req, 1'b0);
    chk1("starve_busy_clr", busy_rs, 1'b0);
    chk1("starve_idle_rw", regwrite, 1'b0);
    tick();

    // Double issue to the same register, and issue to $0.
    idle();
    rs_a = 5'd9;
    iss_valid = 1'b1; iss_wa = 5'd9;
    tick();
    #2;
    chk1("err_before", err, 1'b0);
    chk1("err_busy9", busy_rs, 1'b1);
    tick();
    iss_wa = 5'd0; rs_a = 5'd0;
    #2;
    chk1("err_set", err, 1'b1);
    tick();
    iss_valid = 1'b0;
    #2;
    chk1("zero_not_busy", busy_rs, 1'b0);
    repeat (3) tick();
    chk1("err_sticky", err, 1'b1);

    // Asynchronous reset with two FIFO entries and busy bits 1..3.
    idle();
    iss_valid = 1'b1;
    for (int r = 1; r <= 3; r++) begin
      iss_wa = 5'(r);
      tick();
    end
    iss_valid = 1'b0;
    w_we = 1'b1; w_wa = 5'd4;
    sec_if.s_valid = 1'b1; sec_if.s_wa = 5'd1; sec_if.s_wd = 32'h11;
    tick();
    sec_if.s_wa = 5'd2; sec_if.s_wd = 32'h22;
    tick();
    sec_if.s_valid = 1'b0;
    rs_a = 5'd1; rt_a = 5'd2;
    #2;
    chk1("prerst_full", sec_if.s_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk1("arst_regwrite", regwrite, 1'b0);
    chk1("arst_s_ready", sec_if.s_ready, 1'b1);
    chk1("arst_busy_rs", busy_rs, 1'b0);
    chk1("arst_busy_rt", busy_rt, 1'b0);
    chk1("arst_stall", stall_req, 1'b0);
    chk1("arst_err", err, 1'b0);
    tick();
    w_we = 1'b0;
    rs_a = 5'd3;
    tick();
    rst = 1'b1;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      #2;
      chk1($sformatf("postrst_rw%0d", c), regwrite, 1'b0);
      chk1($sformatf("postrst_busy3_%0d", c), busy_rs, 1'b0);
      tick();
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 2000; n++) begin
      int unsigned a;
      bit          illegal;
      idle();
      w_we = !m_stall && ($urandom_range(0, 99) < 55);
      w_wa = 5'($urandom); w_wd = $urandom; w_pc = $urandom;
      rs_a = 5'($urandom); rt_a = 5'($urandom);
      illegal = 1'b0;
      if ($urandom_range(0, 99) < 30) begin
        a = $urandom_range(0, 31);
        if (a == 0 || !m_busy[a]) begin
          iss_valid = 1'b1; iss_wa = 5'(a);
        end else if (n > 1800 && $urandom_range(0, 9) == 0) begin
          iss_valid = 1'b1; iss_wa = 5'(a); illegal = 1'b1;
        end
      end
      if (pend.size() > 0 && $urandom_range(0, 99) < 60) begin
        sec_if.s_valid = 1'b1; sec_if.s_wa = pend[0]; sec_if.s_wd = $urandom;
      end else if ($urandom_range(0, 99) < 5) begin
        sec_if.s_valid = 1'b1; sec_if.s_wa = '0; sec_if.s_wd = $urandom;
      end
      sec_if.s_pc = $urandom;
      #2;
      model_check();
      if (sec_if.s_valid && (mq.size() < DEPTH) && sec_if.s_wa != 0) void'(pend.pop_front());
      if (iss_valid && iss_wa != 0 && !illegal) pend.push_back(iss_wa);
      model_step();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
